// File: rtl/ram_nr1w_clr_if.sv
// Bus bundle for ram_nr1w_clr: clear control, one write port and NUM_RD packed read ports.
// The RAM connects through the slave modport and its user through the master modport.
interface ram_nr1w_clr_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int NUM_RD = 2
);
  logic                     INIT_REQ;
  logic                     INIT_BUSY;
  logic                     INIT_DONE;
  logic                     W_EN;
  logic [ADDR_W-1:0]        W_ADDR;
  logic [DATA_W-1:0]        W_DIN;
  logic [NUM_RD-1:0]        R_EN;
  logic [NUM_RD*ADDR_W-1:0] R_ADDR;
  logic [NUM_RD*DATA_W-1:0] R_DOUT;
  logic [NUM_RD-1:0]        R_VLD;

  modport master (
    output INIT_REQ, W_EN, W_ADDR, W_DIN, R_EN, R_ADDR,
    input  INIT_BUSY, INIT_DONE, R_DOUT, R_VLD
  );

  modport slave (
    input  INIT_REQ, W_EN, W_ADDR, W_DIN, R_EN, R_ADDR,
    output INIT_BUSY, INIT_DONE, R_DOUT, R_VLD
  );
endinterface

// File: rtl/ram_nr1w_clr.sv
// Multi-read, single-write RAM with a two-cycle registered read path, selectable
// read-during-write bypass and a clear sequencer that fills the array after every reset.
module ram_nr1w_clr #(
  parameter int              DATA_W   = 8,
  parameter int              ADDR_W   = 6,
  parameter int              DEPTH    = 64,
  parameter int              NUM_RD   = 2,
  parameter int              BYPASS   = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input logic           CLK,
  input logic           RST,
  ram_nr1w_clr_if.slave bus
);
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;
  localparam int         AW1      = ADDR_W + 1;
  localparam logic [ADDR_W:0]   DEPTH_W   = AW1'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem [DEPTH];

  // Stage 1 holds the array word captured at the address edge, stage 2 the
  // registered array output, and the last stage drives R_DOUT/R_VLD.
  logic [NUM_RD-1:0]             vld1_q, vld1_d, vld2_q, vld2_d, vld_q, vld_d;
  logic [NUM_RD-1:0][DATA_W-1:0] dat1_q, dat1_d, dat2_q, dat2_d, dout_q, dout_d;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_W;
  endfunction

  always_comb begin
    logic [ADDR_W-1:0] ra;
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    ra        = '0;
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = cnt_q;
    mem_wdata = INIT_VAL;
    vld1_d    = '0;
    dat1_d    = dat1_q;

    if (state_q == ST_CLEAR) begin
      mem_we = 1'b1;
      if (cnt_q == LAST_ADDR) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      for (int k = 0; k < NUM_RD; k++) begin
        if (bus.R_EN[k]) begin
          ra        = bus.R_ADDR[k*ADDR_W +: ADDR_W];
          vld1_d[k] = 1'b1;
          if (!in_range(ra))
            dat1_d[k] = '0;
          else if ((BYPASS != 0) && bus.W_EN && (bus.W_ADDR == ra))
            dat1_d[k] = bus.W_DIN;
          else
            dat1_d[k] = mem[ra];
        end
      end
      mem_we    = bus.W_EN && in_range(bus.W_ADDR);
      mem_waddr = bus.W_ADDR;
      mem_wdata = bus.W_DIN;
      // A request restarts the clear; traffic at this same edge still completes.
      if (bus.INIT_REQ) begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    end

    vld2_d = vld1_q;
    dat2_d = dat1_q;
    vld_d  = vld2_q;
    for (int k = 0; k < NUM_RD; k++)
      dout_d[k] = vld2_q[k] ? dat2_q[k] : dout_q[k];
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      vld1_q  <= '0;
      vld2_q  <= '0;
      vld_q   <= '0;
      dat1_q  <= '0;
      dat2_q  <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      vld1_q  <= vld1_d;
      vld2_q  <= vld2_d;
      vld_q   <= vld_d;
      dat1_q  <= dat1_d;
      dat2_q  <= dat2_d;
      dout_q  <= dout_d;
    end
  end

  // NOTE: the array has no reset so it maps onto RAM; the clear sequencer initialises it.
  always_ff @(posedge CLK) begin
    if (mem_we)
      mem[mem_waddr] <= mem_wdata;
  end

  assign bus.INIT_BUSY = (state_q == ST_CLEAR);
  assign bus.INIT_DONE = done_q;
  assign bus.R_VLD     = vld_q;
  assign bus.R_DOUT    = dout_q;
endmodule

// File: tb/tb_ram_nr1w_clr.sv
// Randomised and directed bench for ram_nr1w_clr: a 64-word bypassing instance and a
// 48-word non-bypassing instance share stimulus and are both checked against a word-level model.
module tb_ram_nr1w_clr;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic            w_en, init_req;
  logic [5:0]      w_addr;
  logic [7:0]      w_din;
  logic [1:0]      r_en;
  logic [1:0][5:0] r_addr;

  ram_nr1w_clr_if #(.DATA_W(8), .ADDR_W(6), .NUM_RD(2)) bus_a();
  ram_nr1w_clr_if #(.DATA_W(8), .ADDR_W(6), .NUM_RD(2)) bus_b();

  assign bus_a.INIT_REQ = init_req;
  assign bus_a.W_EN     = w_en;
  assign bus_a.W_ADDR   = w_addr;
  assign bus_a.W_DIN    = w_din;
  assign bus_a.R_EN     = r_en;
  assign bus_a.R_ADDR   = r_addr;
  assign bus_b.INIT_REQ = init_req;
  assign bus_b.W_EN     = w_en;
  assign bus_b.W_ADDR   = w_addr;
  assign bus_b.W_DIN    = w_din;
  assign bus_b.R_EN     = r_en;
  assign bus_b.R_ADDR   = r_addr;

  ram_nr1w_clr #(.DATA_W(8), .ADDR_W(6), .DEPTH(64), .NUM_RD(2), .BYPASS(1), .INIT_VAL(8'h00))
    dut_a (.CLK(clk), .RST(rst), .bus(bus_a));
  ram_nr1w_clr #(.DATA_W(8), .ADDR_W(6), .DEPTH(48), .NUM_RD(2), .BYPASS(0), .INIT_VAL(8'h5A))
    dut_b (.CLK(clk), .RST(rst), .bus(bus_b));

  logic [1:0]       o_busy, o_done;
  logic [1:0][1:0]  o_vld;
  logic [1:0][15:0] o_dout;
  assign o_busy = {bus_b.INIT_BUSY, bus_a.INIT_BUSY};
  assign o_done = {bus_b.INIT_DONE, bus_a.INIT_DONE};
  assign o_vld  = {bus_b.R_VLD, bus_a.R_VLD};
  assign o_dout = {bus_b.R_DOUT, bus_a.R_DOUT};

  // Reference model: plain word array per instance, a remaining-clear-writes count,
  // and a list of reads that are due for delivery at a given edge number.
  typedef struct {
    int         due;
    int         inst;
    int         port;
    logic [7:0] data;
  } rd_t;

  int         depth [2] = '{64, 48};
  bit         bypass[2] = '{1'b1, 1'b0};
  logic [7:0] ival  [2] = '{8'h00, 8'h5A};
  logic [7:0] mem   [2][64];
  int         clr_left[2];
  bit         exp_done[2];
  bit         exp_vld [2][2];
  logic [7:0] exp_dout[2][2];
  rd_t        pend[$];
  int         cyc = 0;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    for (int i = 0; i < 2; i++) begin
      clr_left[i] = depth[i];
      exp_done[i] = 1'b0;
      for (int k = 0; k < 2; k++) begin
        exp_vld[i][k]  = 1'b0;
        exp_dout[i][k] = 8'h00;
      end
    end
  endtask

  task automatic model_edge();
    logic [7:0] d;
    int         a;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      exp_done[i] = 1'b0;
      if (clr_left[i] > 0) begin
        mem[i][depth[i] - clr_left[i]] = ival[i];
        clr_left[i]--;
        if (clr_left[i] == 0) exp_done[i] = 1'b1;
      end else begin
        for (int k = 0; k < 2; k++) begin
          if (r_en[k]) begin
            a = int'(r_addr[k]);
            if (a >= depth[i])                                   d = 8'h00;
            else if (bypass[i] && w_en && int'(w_addr) == a)     d = w_din;
            else                                                 d = mem[i][a];
            pend.push_back('{cyc + 2, i, k, d});
          end
        end
        if (w_en && int'(w_addr) < depth[i]) mem[i][w_addr] = w_din;
        if (init_req) clr_left[i] = depth[i];
      end
    end
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 2; k++) exp_vld[i][k] = 1'b0;
    for (int j = pend.size() - 1; j >= 0; j--) begin
      if (pend[j].due == cyc) begin
        exp_vld[pend[j].inst][pend[j].port]  = 1'b1;
        exp_dout[pend[j].inst][pend[j].port] = pend[j].data;
        pend.delete(j);
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("busy[%0d]", i), 32'(o_busy[i]), 32'(clr_left[i] > 0));
      check($sformatf("done[%0d]", i), 32'(o_done[i]), 32'(exp_done[i]));
      for (int k = 0; k < 2; k++) begin
        check($sformatf("vld[%0d][%0d]", i, k), 32'(o_vld[i][k]), 32'(exp_vld[i][k]));
        check($sformatf("dout[%0d][%0d]", i, k), 32'(o_dout[i][k*8 +: 8]), 32'(exp_dout[i][k]));
      end
    end
  endtask

  always @(posedge clk) begin
    if (rst) model_reset();
    else     model_edge();
    #1;
    compare_all();
  end

  task automatic drive(input logic we, input logic [5:0] wa, input logic [7:0] wd,
                       input logic [1:0] re, input logic [5:0] ra0, input logic [5:0] ra1,
                       input logic ir);
    w_en = we; w_addr = wa; w_din = wd;
    r_en = re; r_addr[0] = ra0; r_addr[1] = ra1;
    init_req = ir;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 6'd0, 8'h00, 2'b00, 6'd0, 6'd0, 1'b0);
  endtask

  task automatic rand_cycle(input bit allow_init);
    logic [5:0] wa;
    wa = 6'($urandom_range(63));
    drive(1'($urandom_range(1)), wa, 8'($urandom), 2'($urandom_range(3)),
          ($urandom_range(3) == 0) ? wa : 6'($urandom_range(63)),
          ($urandom_range(3) == 0) ? wa : 6'($urandom_range(63)),
          allow_init && ($urandom_range(99) == 0));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (clr_left[0] == 0 && clr_left[1] == 0) return;
      idle();
    end
    n_vec++;
    n_err++;
    $display("FAIL wait_idle: clear still running after 200 cycles");
  endtask

  task automatic read_all();
    for (int a = 0; a < 64; a++) drive(1'b0, 6'd0, 8'h00, 2'b11, 6'(a), 6'(63 - a), 1'b0);
    idle();
    idle();
  endtask

  initial begin
    int edges, dones;
    w_en = 1'b0; w_addr = '0; w_din = '0; r_en = '0; r_addr = '0; init_req = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Traffic during the power-on clear must be ignored.
    repeat (70) rand_cycle(1'b0);
    wait_idle();
    read_all();

    // Write then read the same word on both ports one cycle later.
    drive(1'b1, 6'd3, 8'hA5, 2'b00, 6'd0, 6'd0, 1'b0);
    drive(1'b0, 6'd0, 8'h00, 2'b11, 6'd3, 6'd3, 1'b0);
    idle();
    idle();
    check("a5_port0", 32'(o_dout[0][7:0]),  32'h A5);
    check("a5_port1", 32'(o_dout[0][15:8]), 32'h A5);

    // Same-edge collision: bypassing instance sees new data, the other old data.
    drive(1'b1, 6'd7, 8'h11, 2'b00, 6'd0, 6'd0, 1'b0);
    idle();
    drive(1'b1, 6'd7, 8'h22, 2'b01, 6'd7, 6'd0, 1'b0);
    idle();
    idle();
    check("coll_bypass", 32'(o_dout[0][7:0]), 32'h22);
    check("coll_old",    32'(o_dout[1][7:0]), 32'h11);

    // Fill with 0xFF, then clear on request with a read issued at the same edge.
    for (int a = 0; a < 64; a++) drive(1'b1, 6'(a), 8'hFF, 2'b00, 6'd0, 6'd0, 1'b0);
    drive(1'b0, 6'd0, 8'h00, 2'b10, 6'd0, 6'd5, 1'b1);
    idle();
    idle();
    check("req_read_a", 32'(o_dout[0][15:8]), 32'hFF);
    check("req_read_b", 32'(o_dout[1][15:8]), 32'hFF);
    repeat (40) rand_cycle(1'b0);
    wait_idle();
    read_all();

    // Out-of-range write and read on the 48-word instance.
    drive(1'b1, 6'd50, 8'h77, 2'b00, 6'd0, 6'd0, 1'b0);
    drive(1'b0, 6'd0, 8'h00, 2'b11, 6'd50, 6'd47, 1'b0);
    idle();
    idle();
    check("oor_vld",   32'(o_vld[1]),         32'h3);
    check("oor_dout",  32'(o_dout[1][7:0]),   32'h00);
    check("last_word", 32'(o_dout[1][15:8]),  32'h5A);

    repeat (1500) rand_cycle(1'b1);
    wait_idle();

    // Reset with a read in flight, then reset again at clear count 20.
    drive(1'b0, 6'd0, 8'h00, 2'b11, 6'd1, 6'd2, 1'b0);
    rst = 1'b1;
    idle();
    idle();
    rst = 1'b0;
    repeat (20) idle();
    rst = 1'b1;
    repeat (3) idle();
    rst = 1'b0;
    edges = 0;
    dones = 0;
    for (int i = 0; i < 200; i++) begin
      idle();
      edges++;
      if (o_done[0]) dones++;
      if (!o_busy[0]) break;
    end
    repeat (5) begin
      idle();
      if (o_done[0]) dones++;
    end
    check("clear_len",   32'(edges), 32'd64);
    check("done_pulses", 32'(dones), 32'd1);

    repeat (200) rand_cycle(1'b1);
    wait_idle();
    read_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
